// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serdes serializer/deserializer path.
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A one-word frame still needs a legal, non-zero vector width.
    function automatic int count_width(input int n_samples);
        return (n_samples > 1) ? $clog2(n_samples) : 1;
    endfunction

endpackage

// File: rtl/serdes_serializer_control.sv
// Handshake FSM and word index for the serializer.
// Accepts a frame in IDLE and walks the word index in SEND.
module serdes_serializer_control
    import serdes_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int COUNT_W   = count_width(N_SAMPLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               recv_val,
    input  logic               send_rdy,
    output logic               recv_rdy,
    output logic               send_val,
    output logic               load,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(N_SAMPLES - 1);

    state_t state;

    // recv_rdy is itself a flop, so load reaches only the buffer enable.
    assign load = recv_val && recv_rdy;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (recv_val) begin
                        state    <= SEND;
                        count    <= '0;
                        recv_rdy <= 1'b0;
                        send_val <= 1'b1;
                    end
                end
                SEND: begin
                    if (send_rdy) begin
                        if (count == LAST) begin
                            state    <= IDLE;
                            count    <= '0;
                            recv_rdy <= 1'b1;
                            send_val <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    recv_rdy <= 1'b1;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/serdes_serializer.sv
// Parallel-to-serial converter: captures one frame of N_SAMPLES words and
// emits them index 0 first over a val/rdy stream.
module serdes_serializer
    import serdes_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg
);

    localparam int COUNT_W = count_width(N_SAMPLES);

    generate
        if (N_SAMPLES == 1) begin : g_bypass
            // A single-word frame needs no storage; the handshake passes straight through.
            assign recv_rdy = send_rdy;
            assign send_val = recv_val;
            assign send_msg = recv_msg[0];

            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
        end else begin : g_serial
            logic                 load;
            logic [COUNT_W-1:0]   count;
            logic [BIT_WIDTH-1:0] buffer [N_SAMPLES];

            serdes_serializer_control #(
                .N_SAMPLES (N_SAMPLES),
                .COUNT_W   (COUNT_W)
            ) u_ctrl (
                .clk      (clk),
                .reset    (reset),
                .recv_val (recv_val),
                .send_rdy (send_rdy),
                .recv_rdy (recv_rdy),
                .send_val (send_val),
                .load     (load),
                .count    (count)
            );

            // NOTE: the frame buffer is a small register array, not a RAM,
            // so it takes the async clear and send_msg reads 0 during reset.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < N_SAMPLES; i++) buffer[i] <= '0;
                end else if (load) begin
                    for (int i = 0; i < N_SAMPLES; i++) buffer[i] <= recv_msg[i];
                end
            end

            // count rests at 0 in IDLE, so idle output is buffer[0].
            assign send_msg = buffer[count];
        end
    endgenerate

endmodule

// File: tb/tb_serdes_serializer.sv
// Bench for serdes_serializer: queue-based frame model compared every cycle,
// plus literal expectations for the directed scenarios (N=8, N=5, N=1).
module tb_serdes_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT instances ----------------
    logic        rst8, recv_val8, send_rdy8, recv_rdy8, send_val8;
    logic [31:0] recv_msg8 [8];
    logic [31:0] send_msg8;

    logic        rst5, recv_val5, send_rdy5, recv_rdy5, send_val5;
    logic [31:0] recv_msg5 [5];
    logic [31:0] send_msg5;

    logic        rst1, recv_val1, send_rdy1, recv_rdy1, send_val1;
    logic [31:0] recv_msg1 [1];
    logic [31:0] send_msg1;

    serdes_serializer #(.N_SAMPLES(8), .BIT_WIDTH(32)) d8 (
        .clk(clk), .reset(rst8), .recv_val(recv_val8), .recv_rdy(recv_rdy8),
        .recv_msg(recv_msg8), .send_val(send_val8), .send_rdy(send_rdy8), .send_msg(send_msg8)
    );
    serdes_serializer #(.N_SAMPLES(5), .BIT_WIDTH(32)) d5 (
        .clk(clk), .reset(rst5), .recv_val(recv_val5), .recv_rdy(recv_rdy5),
        .recv_msg(recv_msg5), .send_val(send_val5), .send_rdy(send_rdy5), .send_msg(send_msg5)
    );
    serdes_serializer #(.N_SAMPLES(1), .BIT_WIDTH(32)) d1 (
        .clk(clk), .reset(rst1), .recv_val(recv_val1), .recv_rdy(recv_rdy1),
        .recv_msg(recv_msg1), .send_val(send_val1), .send_rdy(send_rdy1), .send_msg(send_msg1)
    );

    // ---------------- Behavioural model ----------------
    // A frame is a queue of pending words; the block is ready exactly when
    // nothing is pending, and idles showing word 0 of the last accepted frame.
    logic [31:0] q8 [$];
    logic [31:0] q5 [$];
    logic [31:0] w0_8, w0_5;

    always @(posedge clk or negedge rst8) begin
        if (!rst8) begin
            q8.delete();
            w0_8 = '0;
        end else if (q8.size() != 0) begin
            if (send_rdy8) void'(q8.pop_front());
        end else if (recv_val8) begin
            for (int i = 0; i < 8; i++) q8.push_back(recv_msg8[i]);
            w0_8 = recv_msg8[0];
        end
    end

    always @(posedge clk or negedge rst5) begin
        if (!rst5) begin
            q5.delete();
            w0_5 = '0;
        end else if (q5.size() != 0) begin
            if (send_rdy5) void'(q5.pop_front());
        end else if (recv_val5) begin
            for (int i = 0; i < 5; i++) q5.push_back(recv_msg5[i]);
            w0_5 = recv_msg5[0];
        end
    end

    // ---------------- Compare + fire monitor (negedge) ----------------
    logic [31:0] fired8 [$];
    int          fire_cyc8 [$];
    logic [31:0] fired5 [$];

    always @(negedge clk) begin
        cyc++;
        check("m8_recv_rdy", {31'b0, recv_rdy8}, {31'b0, q8.size() == 0});
        check("m8_send_val", {31'b0, send_val8}, {31'b0, q8.size() != 0});
        check("m8_send_msg", send_msg8, (q8.size() != 0) ? q8[0] : w0_8);
        check("m5_recv_rdy", {31'b0, recv_rdy5}, {31'b0, q5.size() == 0});
        check("m5_send_val", {31'b0, send_val5}, {31'b0, q5.size() != 0});
        check("m5_send_msg", send_msg5, (q5.size() != 0) ? q5[0] : w0_5);
        check("n5_count_le_4", {31'b0, d5.g_serial.count <= 3'd4}, 32'd1);
        if (rst8 && send_val8 && send_rdy8) begin
            fired8.push_back(send_msg8);
            fire_cyc8.push_back(cyc);
        end
        if (rst5 && send_val5 && send_rdy5) fired5.push_back(send_msg5);
    end

    // ---------------- Stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame8(input logic [31:0] base);
        for (int i = 0; i < 8; i++) recv_msg8[i] = base + 32'(i);
    endtask

    task automatic fire8_and_check(input logic [31:0] base, input string tag);
        set_frame8(base);
        recv_val8 = 1'b1;
        send_rdy8 = 1'b1;
        step();
        recv_val8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_word"}, send_msg8, base + 32'(i));
            check({tag, "_recv_rdy_low"}, {31'b0, recv_rdy8}, 32'd0);
            step();
        end
        @(negedge clk);
        check({tag, "_recv_rdy_back"}, {31'b0, recv_rdy8}, 32'd1);
        check({tag, "_send_val_off"}, {31'b0, send_val8}, 32'd0);
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bp_pat;
        rst8 = 0; rst5 = 0; rst1 = 0;
        recv_val8 = 0; send_rdy8 = 0; set_frame8(32'h0);
        recv_val5 = 0; send_rdy5 = 0;
        for (int i = 0; i < 5; i++) recv_msg5[i] = '0;
        recv_val1 = 0; send_rdy1 = 0; recv_msg1[0] = '0;

        // Reset state
        repeat (2) step();
        check("rst_recv_rdy", {31'b0, recv_rdy8}, 32'd1);
        check("rst_send_val", {31'b0, send_val8}, 32'd0);
        check("rst_send_msg", send_msg8, 32'd0);
        rst8 = 1; rst5 = 1; rst1 = 1;
        step();

        // Basic frame
        fire8_and_check(32'h10, "basic");
        check("idle_shows_word0", send_msg8, 32'h10);

        // Backpressure with a mid-frame recv_val pulse
        fired8.delete();
        set_frame8(32'h20);
        recv_val8 = 1; send_rdy8 = 0;
        step();
        recv_val8 = 0;
        bp_pat = 4'b1001;
        for (int c = 0; c < 40; c++) begin
            send_rdy8 = bp_pat[c % 4];
            if (c == 3) begin
                set_frame8(32'hF0);
                recv_val8 = 1;
            end
            if (c == 5) recv_val8 = 0;
            step();
        end
        send_rdy8 = 0;
        check("bp_fire_count", fired8.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < fired8.size()) check("bp_fire_order", fired8[i], 32'h20 + 32'(i));
        step();

        // Back-to-back frames A then B
        fired8.delete(); fire_cyc8.delete();
        set_frame8(32'hA0);
        recv_val8 = 1; send_rdy8 = 1;
        step();
        set_frame8(32'hB0);
        repeat (8) step();
        @(posedge clk); #1;
        recv_val8 = 0;
        repeat (10) step();
        check("b2b_fire_count", fired8.size(), 32'd16);
        if (fired8.size() == 16) begin
            check("b2b_first_a", fired8[0], 32'hA0);
            check("b2b_last_a", fired8[7], 32'hA7);
            check("b2b_first_b", fired8[8], 32'hB0);
            check("b2b_last_b", fired8[15], 32'hB7);
            check("b2b_period", 32'(fire_cyc8[8] - fire_cyc8[0]), 32'd9);
        end

        // Reset mid-frame after word 3 fires
        set_frame8(32'h30);
        recv_val8 = 1; send_rdy8 = 1;
        step();
        recv_val8 = 0;
        repeat (4) @(posedge clk);
        #3;
        rst8 = 0;
        #1;
        check("midrst_send_val", {31'b0, send_val8}, 32'd0);
        check("midrst_recv_rdy", {31'b0, recv_rdy8}, 32'd1);
        check("midrst_send_msg", send_msg8, 32'd0);
        set_frame8(32'h55);
        recv_val8 = 1;
        step();
        recv_val8 = 0;
        #2;
        rst8 = 1;
        #1;
        check("postrst_send_msg", send_msg8, 32'd0);
        check("postrst_send_val", {31'b0, send_val8}, 32'd0);
        step();
        fire8_and_check(32'h1, "after_rst");

        // N=5 frame
        fired5.delete();
        for (int i = 0; i < 5; i++) recv_msg5[i] = 32'(5 + i);
        recv_val5 = 1; send_rdy5 = 1;
        step();
        recv_val5 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("n5_word", send_msg5, 32'(5 + i));
            step();
        end
        @(negedge clk);
        check("n5_idle_rdy", {31'b0, recv_rdy5}, 32'd1);
        check("n5_fire_count", fired5.size(), 32'd5);
        step();
        // N=5 under backpressure, model only
        for (int i = 0; i < 5; i++) recv_msg5[i] = 32'h50 + 32'(i);
        recv_val5 = 1;
        step();
        recv_val5 = 0;
        for (int c = 0; c < 16; c++) begin
            send_rdy5 = (c % 3) != 1;
            step();
        end

        // N=1 combinational pass-through
        for (int k = 0; k < 4; k++) begin
            recv_val1 = k[0];
            send_rdy1 = k[1];
            recv_msg1[0] = 32'hC0DE_0000 + 32'(k * 17);
            #1;
            check("n1_send_val", {31'b0, send_val1}, {31'b0, k[0]});
            check("n1_recv_rdy", {31'b0, recv_rdy1}, {31'b0, k[1]});
            check("n1_send_msg", send_msg1, 32'hC0DE_0000 + 32'(k * 17));
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serdes_serializer.md
# serdes_serializer

Parallel-to-serial converter for the serdes path. It accepts one frame of `N_SAMPLES` words of `BIT_WIDTH` bits through a val/rdy handshake and emits the words one at a time, index 0 first, through a second val/rdy handshake. It is the transmit-side counterpart of the serdes deserializer: a frame produced by the deserializer, fed through this block, reproduces the original word stream in order.

## Interface
Parameters:
- `N_SAMPLES`, default 8: words per frame; must be ≥ 1; need not be a power of two.
- `BIT_WIDTH`, default 32: bits per word.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; asserted when 0.
- `recv_val`  in  1: input frame valid.
- `recv_rdy`  out  1: block can accept a frame.
- `recv_msg`  in  `BIT_WIDTH` × `N_SAMPLES` (unpacked array): frame words, element 0 sent first.
- `send_val`  out  1: `send_msg` is valid.
- `send_rdy`  in  1: downstream accepts the word.
- `send_msg`  out  `BIT_WIDTH`: current output word.

## Operation
- Fire rule on both interfaces: a transfer occurs in a cycle where val and rdy are both 1 at the rising edge.
- FSM states:
  - IDLE: `recv_rdy`=1, `send_val`=0. On recv fire, all `N_SAMPLES` words are captured into a buffer, `count` is set to 0, and the FSM moves to SEND.
  - SEND: `recv_rdy`=0, `send_val`=1, `send_msg`=buffer[`count`]. On send fire:
    - if `count` == `N_SAMPLES`-1, `count` is set to 0 and the FSM moves to IDLE;
    - otherwise `count` increments.
  - No send fire: state, `count` and the buffer hold.
- `count` is `$clog2(N_SAMPLES)` bits wide. The terminal compare uses `N_SAMPLES`-1 truncated to that width, so `count` never exceeds `N_SAMPLES`-1. Unused `count` values are unreachable.
- The buffer is written only on recv fire. `recv_msg` is ignored at all other times.
- `send_msg` in IDLE outputs buffer[0]. Its value there is don't-care for protocol purposes, but it must be deterministic.
- `N_SAMPLES` == 1: purely combinational pass-through. `recv_rdy`=`send_rdy`, `send_val`=`recv_val`, `send_msg`=`recv_msg[0]`. `clk` and `reset` are unused and tied to an unused sink.
- Reset assertion, at any time including mid-frame, immediately:
  - forces IDLE and `count`=0;
  - clears the buffer to 0;
  - drives `send_val`=0, `recv_rdy`=1 and `send_msg`=0.
  - Any partially sent frame is discarded.
  - A recv fire coinciding with an edge while reset is asserted has no effect.

## Timing
- Latency: the first word is valid on `send_msg` the cycle after recv fire.
- Frame period with `send_rdy` held at 1 is `N_SAMPLES`+1 cycles: 1 accept cycle plus `N_SAMPLES` send cycles.
- No overlap: `recv_rdy` rises only in the cycle after the last send fire.
- Handshake rules:
  - `recv_rdy` and `send_val` are decoded from registered state only.
  - There is no combinational path from `send_rdy` or `recv_val` to any output.
  - Once asserted, `send_val` stays 1 and `send_msg` stays stable until fire.
- Backpressure: any number of `send_rdy`=0 cycles may be inserted between words, and no word is lost or repeated.

## Structure
- Shared package `serdes_pkg`:
  - state enum typedef (IDLE, SEND);
  - a width helper for the `count` width.
- Sub-module `serdes_serializer_control` holds:
  - the FSM and `count`;
  - outputs `recv_rdy`, `send_val`, `count`, and `load` (recv fire).
- The top level holds:
  - the `N_SAMPLES` buffer registers, with async active-low clear and enable = `load`;
  - the `send_msg` read mux indexed by `count`;
  - the `N_SAMPLES` == 1 generate bypass.

## Test plan
- Basic frame (N=8, W=32): frame {0x10..0x17} with `send_rdy`=1 → `send_msg` 0x10..0x17 on 8 consecutive cycles starting 1 cycle after fire. `recv_rdy`=0 throughout, then 1 on the following cycle.
- Backpressure: `send_rdy` toggling 1,0,0,1,… → each word is held stable while `send_val`=1, with exactly 8 fires in order. `recv_val` pulsed mid-frame is ignored and the buffer is unchanged.
- Back-to-back frames A={0xA0..0xA7} and B={0xB0..0xB7}, both `recv_val` and `send_rdy` held at 1 → output A0..A7, then one idle cycle, then B0..B7. Period is 9 cycles.
- Reset mid-frame: assert `reset`=0 asynchronously after word 3 fires → `send_val`=0, `recv_rdy`=1 and `send_msg`=0 immediately. After release, a new frame {1..8} emits 1..8 from index 0.
- Non-power-of-two (N=5) and N=1:
  - N=5: frame {5,6,7,8,9} → 5 words, then IDLE; `count` never exceeds 4.
  - N=1: `send_msg`/`send_val` follow `recv_msg[0]`/`recv_val` combinationally, and `recv_rdy` follows `send_rdy`.
